// File: rtl/eth_frame_arb.sv
// Two-source AXI-Stream byte arbiter: whole-frame round-robin, MAX_FRAME truncation with drain.
// Define FRAME_ARB_IFG_EN to enforce an inter-frame gap of IFG_CYCLES dead cycles between frames.
module eth_frame_arb #(
    parameter int MAX_FRAME  = 1518,
    parameter int IFG_CYCLES = 12
) (
    input  logic       rx_clk,
    input  logic       rst_n,
    input  logic [7:0] s0_axis_tdata,
    input  logic       s0_axis_tvalid,
    input  logic       s0_axis_tlast,
    input  logic       s0_axis_tuser,
    output logic       s0_axis_tready,
    input  logic [7:0] s1_axis_tdata,
    input  logic       s1_axis_tvalid,
    input  logic       s1_axis_tlast,
    input  logic       s1_axis_tuser,
    output logic       s1_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    input  logic       m_axis_tready,
    output logic [1:0] grant,
    output logic       trunc_pulse
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_BUSY  = 2'd1;
    localparam logic [1:0]  ST_DRAIN = 2'd2;
    localparam logic [1:0]  ST_GAP   = 2'd3;
    localparam logic [10:0] LAST_BEAT = 11'(MAX_FRAME - 1);
`ifdef FRAME_ARB_IFG_EN
    localparam bit IFG_EN = 1'b1;
`else
    localparam bit IFG_EN = 1'b0;
`endif
    // GAP plus the arbitration cycle in IDLE together make IFG_CYCLES dead cycles.
    localparam logic [1:0] ST_AFTER = (IFG_EN && IFG_CYCLES > 1) ? ST_GAP : ST_IDLE;

    logic [1:0]  r_state;
    logic [1:0]  r_grant;
    logic        r_rr_ptr;
    logic [10:0] r_beat_cnt;
    logic        r_trunc_pulse;
`ifdef FRAME_ARB_IFG_EN
    logic [15:0] r_gap_cnt;
`endif

    logic       w_sel;
    logic [7:0] w_src_data;
    logic       w_src_valid;
    logic       w_src_last;
    logic       w_src_user;
    logic       w_busy;
    logic       w_drain;
    logic       w_src_ready;
    logic       w_hs;
    logic       w_at_max;
    logic       w_force;

    assign w_sel       = r_grant[1];
    assign w_src_data  = w_sel ? s1_axis_tdata  : s0_axis_tdata;
    assign w_src_valid = w_sel ? s1_axis_tvalid : s0_axis_tvalid;
    assign w_src_last  = w_sel ? s1_axis_tlast  : s0_axis_tlast;
    assign w_src_user  = w_sel ? s1_axis_tuser  : s0_axis_tuser;

    assign w_busy      = (r_state == ST_BUSY);
    assign w_drain     = (r_state == ST_DRAIN);
    assign w_src_ready = (w_busy & m_axis_tready) | w_drain;
    assign w_hs        = w_src_valid & w_src_ready;
    assign w_at_max    = (r_beat_cnt == LAST_BEAT);
    // A source tlast on the final allowed beat is a normal end, not a truncation.
    assign w_force     = w_at_max & ~w_src_last;

    assign s0_axis_tready = w_src_ready & r_grant[0];
    assign s1_axis_tready = w_src_ready & r_grant[1];
    assign m_axis_tdata   = w_busy ? w_src_data : 8'h00;
    assign m_axis_tvalid  = w_busy & w_src_valid;
    assign m_axis_tlast   = w_busy & (w_src_last | w_at_max);
    assign m_axis_tuser   = w_busy & (w_src_user | w_force);
    assign grant          = r_grant;
    assign trunc_pulse    = r_trunc_pulse;

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_grant       <= 2'b00;
            r_rr_ptr      <= 1'b1;
            r_beat_cnt    <= 11'd0;
            r_trunc_pulse <= 1'b0;
`ifdef FRAME_ARB_IFG_EN
            r_gap_cnt     <= 16'd0;
`endif
        end else begin
            r_trunc_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (s0_axis_tvalid || s1_axis_tvalid) begin
                        // r_rr_ptr holds the last source served; the other one wins a tie.
                        if (s0_axis_tvalid && (!s1_axis_tvalid || r_rr_ptr))
                            r_grant <= 2'b01;
                        else
                            r_grant <= 2'b10;
                        r_beat_cnt <= 11'd0;
                        r_state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_hs) begin
                        r_beat_cnt <= r_beat_cnt + 11'd1;
                        if (w_src_last) begin
                            r_rr_ptr <= w_sel;
                            r_grant  <= 2'b00;
                            r_state  <= ST_AFTER;
`ifdef FRAME_ARB_IFG_EN
                            r_gap_cnt <= 16'(IFG_CYCLES - 2);
`endif
                        end else if (w_at_max) begin
                            r_trunc_pulse <= 1'b1;
                            r_state       <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_hs && w_src_last) begin
                        r_rr_ptr <= w_sel;
                        r_grant  <= 2'b00;
                        r_state  <= ST_AFTER;
`ifdef FRAME_ARB_IFG_EN
                        r_gap_cnt <= 16'(IFG_CYCLES - 2);
`endif
                    end
                end
`ifdef FRAME_ARB_IFG_EN
                ST_GAP: begin
                    if (r_gap_cnt == 16'd0)
                        r_state <= ST_IDLE;
                    else
                        r_gap_cnt <= r_gap_cnt - 16'd1;
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
